// File: rtl/scr_feeder.sv
// scr_feeder: packs a 1-bit serial stream into STEPS-bit words, holds the scrambler
// state and captures the combinational stage's result. Define SCR_FEEDER_WORD_CNT_EN for word_cnt.
module scr_feeder #(
  parameter int WIDTH = 116,
  parameter int STEPS = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] lfsr_load,
  output logic [STEPS-1:0] lfsr_serial,
  input  logic [WIDTH-1:0] lfsr_next,
  output logic [WIDTH-1:0] state_out,
  output logic             out_valid,
  output logic [31:0]      word_cnt
);

  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    STEP = 2'd2
  } fsm_e;

  fsm_e             fsm_q;
  logic [WIDTH-1:0] state_q;
  logic [STEPS-1:0] buf_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic             accept;

  // Ready depends only on the FSM and a pending seed, so a seed always wins the cycle.
  assign s_ready     = (fsm_q == FILL) && !seed_valid;
  assign accept      = s_valid && s_ready;
  assign lfsr_load   = state_q;
  assign lfsr_serial = buf_q;
  assign state_out   = state_q;
  assign out_valid   = out_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (seed_valid) begin
        state_q <= seed;
        buf_q   <= '0;
        cnt_q   <= '0;
        fsm_q   <= FILL;
      end else begin
        case (fsm_q)
          IDLE: begin
          end
          FILL: begin
            if (accept) begin
              buf_q[cnt_q] <= s_data;
              cnt_q        <= cnt_q + CW'(1);
              if (cnt_q == CW'(STEPS - 1)) begin
                fsm_q <= STEP;
              end
            end
          end
          STEP: begin
            state_q     <= lfsr_next;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            fsm_q       <= FILL;
          end
          default: begin
            fsm_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef SCR_FEEDER_WORD_CNT_EN
  logic [31:0] word_cnt_q;

  // A seed during STEP cancels the step, so the clear takes priority over the increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt_q <= '0;
    end else if (seed_valid) begin
      word_cnt_q <= '0;
    end else if (fsm_q == STEP) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign word_cnt = word_cnt_q;
`else
  assign word_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_scr_feeder.sv
// Randomized self-checking bench for scr_feeder; a behavioural scrambler drives lfsr_next
// and a queue-based reference model predicts every output.
module tb_scr_feeder;

  localparam int W = 116;
  localparam int S = 11;

  logic         clk;
  logic         rst;
  logic         seed_valid;
  logic [W-1:0] seed;
  logic         s_valid;
  logic         s_data;
  logic         s_ready;
  logic [W-1:0] lfsr_load;
  logic [S-1:0] lfsr_serial;
  logic [W-1:0] lfsr_next;
  logic [W-1:0] state_out;
  logic         out_valid;
  logic [31:0]  word_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] expState;
  bit           seeded;
  bit           stepNext;
  bit           expOutValid;
  logic [31:0]  expWc;
  bit           bits[$];

  scr_feeder #(.WIDTH(W), .STEPS(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_valid (seed_valid),
    .seed       (seed),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .lfsr_load  (lfsr_load),
    .lfsr_serial(lfsr_serial),
    .lfsr_next  (lfsr_next),
    .state_out  (state_out),
    .out_valid  (out_valid),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Galois-style scrambler: input enters bit 0, bit 115 feeds back into bits 0, 24, 27, 95.
  function automatic logic [W-1:0] scramble(input logic [W-1:0] st, input logic [S-1:0] ser);
    logic [W-1:0] s;
    logic         fb;
    s = st;
    for (int i = 0; i < S; i++) begin
      fb = s[W-1];
      s = s << 1;
      s[0] = fb ^ ser[i];
      s[24] = s[24] ^ fb;
      s[27] = s[27] ^ fb;
      s[95] = s[95] ^ fb;
    end
    return s;
  endfunction

  assign lfsr_next = scramble(lfsr_load, lfsr_serial);

  function automatic logic [S-1:0] packWord();
    logic [S-1:0] w;
    w = '0;
    foreach (bits[i]) w[i] = bits[i];
    return w;
  endfunction

  function automatic logic [W-1:0] randWide();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expVal);
    checks++;
    if (obs !== expVal) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expVal);
    end
  endtask

  task automatic modelReset();
    expState    = '0;
    seeded      = 0;
    stepNext    = 0;
    expOutValid = 0;
    expWc       = '0;
    bits.delete();
  endtask

  function automatic logic [31:0] expWordCnt();
`ifdef SCR_FEEDER_WORD_CNT_EN
    return expWc;
`else
    return 32'h0;
`endif
  endfunction

  // One clock cycle: drive, check the combinational view, advance the model, check registered outputs.
  task automatic applyStimulus(input logic sv, input logic [W-1:0] sd, input logic v, input logic d);
    bit expReady;
    @(negedge clk);
    seed_valid = sv;
    seed       = sd;
    s_valid    = v;
    s_data     = d;
    #1;
    expReady = seeded && !stepNext && !sv;
    checkOutput("s_ready", 128'(s_ready), 128'(expReady));
    checkOutput("lfsr_load", 128'(lfsr_load), 128'(expState));
    if (stepNext) checkOutput("lfsr_serial", 128'(lfsr_serial), 128'(packWord()));
    @(posedge clk);
    expOutValid = 0;
    if (sv) begin
      expState = sd;
      bits.delete();
      seeded   = 1;
      stepNext = 0;
      expWc    = '0;
    end else if (stepNext) begin
      expState    = scramble(expState, packWord());
      bits.delete();
      stepNext    = 0;
      expOutValid = 1;
      expWc       = expWc + 32'd1;
    end else if (v && expReady) begin
      bits.push_back(d);
      if (bits.size() == S) stepNext = 1;
    end
    #1;
    checkOutput("out_valid", 128'(out_valid), 128'(expOutValid));
    checkOutput("state_out", 128'(state_out), 128'(expState));
    checkOutput("word_cnt", 128'(word_cnt), 128'(expWordCnt()));
  endtask

  task automatic feedWord(input logic [S-1:0] w);
    for (int i = 0; i < S; i++) applyStimulus(1'b0, '0, 1'b1, w[i]);
    applyStimulus(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_s_ready"}, 128'(s_ready), 128'(0));
    checkOutput({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    checkOutput({tag, "_state_out"}, 128'(state_out), 128'(0));
    checkOutput({tag, "_lfsr_load"}, 128'(lfsr_load), 128'(0));
    checkOutput({tag, "_lfsr_serial"}, 128'(lfsr_serial), 128'(0));
    checkOutput({tag, "_word_cnt"}, 128'(word_cnt), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] tapsExp;
    logic [W-1:0] sX;
    logic [W-1:0] topBit;
    rst        = 1'b0;
    seed_valid = 1'b0;
    seed       = '0;
    s_valid    = 1'b0;
    s_data     = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] unseeded stream");
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
    checkOutput("unseeded_state", 128'(state_out), 128'(0));

    $display("[TB] zero bits");
    applyStimulus(1'b1, W'(1), 1'b0, 1'b0);
    feedWord('0);
    checkOutput("zero_bits_state", 128'(state_out), 128'(116'h800));
    checkOutput("zero_bits_valid", 128'(out_valid), 128'(1));

    $display("[TB] bit ordering");
    applyStimulus(1'b1, W'(1), 1'b0, 1'b0);
    feedWord(11'h001);
    checkOutput("bit_order_state", 128'(state_out), 128'(116'hC00));

    $display("[TB] feedback taps");
    topBit = '0;
    topBit[W-1] = 1'b1;
    tapsExp = '0;
    tapsExp[10] = 1'b1;
    tapsExp[34] = 1'b1;
    tapsExp[37] = 1'b1;
    tapsExp[105] = 1'b1;
    applyStimulus(1'b1, topBit, 1'b0, 1'b0);
    feedWord('0);
    checkOutput("taps_state", 128'(state_out), 128'(tapsExp));

    $display("[TB] stall and seed override");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b1, W'(1), 1'b1, 1'b1);
    feedWord('0);
    checkOutput("override_state", 128'(state_out), 128'(116'h800));

    $display("[TB] seed during step");
    applyStimulus(1'b1, W'(5), 1'b0, 1'b0);
    for (int i = 0; i < S; i++) applyStimulus(1'b0, '0, 1'b1, 1'($urandom_range(0, 1)));
    sX = randWide();
    applyStimulus(1'b1, sX, 1'b1, 1'b0);
    checkOutput("cancel_valid", 128'(out_valid), 128'(0));
    checkOutput("cancel_state", 128'(state_out), 128'(sX));
    checkOutput("cancel_word_cnt", 128'(word_cnt), 128'(0));

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 149) == 0), randWide(),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, randWide(), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    seed_valid = 1'b0;
    s_valid    = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs("midreset");
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr_feeder.md
# scr_feeder

Sequential feed-and-hold stage for the 116-bit, 11-steps-per-cycle combinational scrambler. It accepts a 1-bit serial stream on a valid/ready handshake and packs 11 bits into a word. It holds the 116-bit scrambler state register, presents that state and the packed word to the combinational stage, and registers the returned next state. The result is published as a one-cycle `out_valid` pulse with the updated state.

## Interface
- `WIDTH`, 116, scrambler state width; must match the combinational stage.
- `STEPS`, 11, bits consumed per scrambler update; must match the combinational stage.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `seed_valid`  in  1  load `seed` into the state register this cycle.
- `seed`  in  WIDTH  initial scrambler state.
- `s_valid`  in  1  serial bit available.
- `s_data`  in  1  serial bit.
- `s_ready`  out  1  bit accepted when `s_valid && s_ready`.
- `lfsr_load`  out  WIDTH  current state register, driven to the scrambler `data_load`.
- `lfsr_serial`  out  STEPS  packed word, driven to the scrambler `serial_in`; bit i is the i-th accepted bit, bit 0 first.
- `lfsr_next`  in  WIDTH  scrambler `data_out`, which is combinational from `lfsr_load`/`lfsr_serial`.
- `state_out`  out  WIDTH  registered scrambler state.
- `out_valid`  out  1  one-cycle pulse: `state_out` was just updated by a scrambler step.
- `word_cnt`  out  32  completed-step counter (see Configuration).

## Operation
- **FSM states:** IDLE (unseeded), FILL, STEP.
- **IDLE**
  - `s_ready`=0.
  - `seed_valid` → state_reg<=seed, bit_cnt<=0, go to FILL.
- **FILL**
  - `s_ready` = !`seed_valid`.
  - On each accepted bit: buf[bit_cnt]<=s_data, bit_cnt++.
  - On the accept with bit_cnt==STEPS-1 → go to STEP.
- **STEP** (exactly one cycle)
  - `s_ready`=0.
  - state_reg<=`lfsr_next`, bit_cnt<=0, out_valid<=1, word_cnt++.
  - Go to FILL.
- **Seed precedence:** `seed_valid` has priority in every state.
  - Reloads state_reg, clears bit_cnt and buf, goes to FILL.
  - Discards any partial word.
  - In STEP: the step is cancelled (no out_valid, no word_cnt increment).
- `lfsr_load` = state_reg; `lfsr_serial` = buf. Both are driven continuously; only the STEP capture is significant.
- `state_out` = state_reg.
- Bits are never dropped: a bit is consumed only on `s_valid && s_ready`.
- The block performs no arithmetic on the data path. `word_cnt` wraps 2^32-1 → 0.

## Timing
- **Reset values:** FSM=IDLE, state_reg=0, buf=0, bit_cnt=0, `out_valid`=0, `word_cnt`=0, `s_ready`=0, `state_out`=0, `lfsr_load`=0, `lfsr_serial`=0.
- **Reset mid-word:** asserting `rst` mid-word aborts immediately; the block requires a new seed afterwards.
- **Throughput:** 11 bits per 12 cycles at best (11 FILL accepts + 1 STEP).
- **Latency:** `out_valid` is high in the cycle after STEP, concurrent with the new `state_out`. It is never high for two consecutive cycles.
- **Stalls:** an `s_valid` gap stalls FILL indefinitely; buf and bit_cnt are held.
- `s_ready` is combinational only from FSM state and `seed_valid`, never from `s_valid`.

## Configuration
- **`SCR_FEEDER_WORD_CNT_EN` defined:** `word_cnt` is a 32-bit register, reset to 0, incremented on every completed STEP, and cleared on `seed_valid`.
- **Undefined:** `word_cnt` is tied to 32'h0 and no counter flops are synthesized.

## Test plan
- **Unseeded:** reset, then `s_valid`=1 for 20 cycles with no seed → `s_ready`=0 throughout, `out_valid` never asserts, `state_out`=0.
- **Zero bits:** seed=116'h1, then 11 zero bits back-to-back → `s_ready` is low during STEP. The cycle after STEP has `out_valid`=1 and `state_out`=116'h800; `word_cnt`=1 when the macro is defined.
- **Bit ordering:** seed=116'h1, first bit 1 then 10 zeros → `state_out`=116'hC00. Confirms bit 0 is shifted in first.
- **Feedback taps:** seed=1<<115, 11 zero bits → `state_out` has exactly bits 10, 34, 37 and 105 set.
- **Stall and seed override:** deliver 5 bits, hold `s_valid` low for 7 cycles, then assert `seed_valid` with seed=116'h1.
  - Partial word is discarded.
  - The next 11 zero bits yield `state_out`=116'h800.
- **Seed during STEP and reset mid-word:**
  - `seed_valid` during the STEP cycle → no `out_valid`, `state_out`=seed, `word_cnt` unchanged.
  - Asserting `rst` low mid-FILL → all outputs return to reset values.
